// File: rtl/disparity_frame_writer.sv
// disparity_frame_writer
// Packs a raster-order 6-bit disparity stream into 32-bit words, four pixels
// per word, with byte 0 holding the earliest pixel. Each completed word is
// tagged with its frame-buffer word address. It is then queued in a small
// first-word-fall-through FIFO that drives a valid/ready memory write port.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   disp_in         6-bit disparity sample
//   disp_valid      sample strobe (no back-pressure)
//   sof             start of frame, qualified by disp_valid
//   mem_addr/data   head entry of the FIFO (0 when empty)
//   mem_wvalid      FIFO not empty
//   mem_wready      memory accepts the head entry
//   frame_done      one-cycle pulse after the last word of a frame is written
//   overflow        sticky flag: a completed word was dropped
//   ovf_clear       clears overflow (a simultaneous drop wins)
module disparity_frame_writer #(
   parameter int FRAME_WIDTH  = 272,
   parameter int FRAME_HEIGHT = 240,
   parameter int FIFO_DEPTH   = 8,
   parameter int ADDR_WIDTH   = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [5:0]            disp_in,
   input  logic                  disp_valid,
   input  logic                  sof,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_data,
   output logic                  mem_wvalid,
   input  logic                  mem_wready,
   output logic                  frame_done,
   output logic                  overflow,
   input  logic                  ovf_clear
);

   localparam int                    WORDS     = FRAME_WIDTH * FRAME_HEIGHT / 4;
   localparam int                    PW        = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);
   localparam logic [PW:0]           DEPTH_C   = (PW + 1)'(FIFO_DEPTH);

   // ---------------- packing ----------------
   logic [1:0]            lane_q, lane_d, cur_lane;
   logic [23:0]           stage_q, stage_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, cur_addr;
   logic [7:0]            pix;
   logic                  push;
   logic [31:0]           push_data;

   always_comb begin
      // sof restarts the frame: the current sample becomes byte 0 of word 0
      // and whatever was staged is simply overwritten later.
      cur_lane  = sof ? 2'd0 : lane_q;
      cur_addr  = sof ? '0 : wr_addr_q;
      pix       = {2'b00, disp_in};
      lane_d    = lane_q;
      stage_d   = stage_q;
      wr_addr_d = wr_addr_q;
      push      = 1'b0;
      push_data = {pix, stage_q};
      if (disp_valid) begin
         lane_d = cur_lane + 2'd1;   // 3 wraps to 0
         if (cur_lane == 2'd3) begin
            push      = 1'b1;
            // Advances even if the word is dropped, keeping later words aligned.
            wr_addr_d = (cur_addr == LAST_ADDR) ? '0 : cur_addr + 1'b1;
         end else begin
            wr_addr_d = cur_addr;
            case (cur_lane)
               2'd0:    stage_d[7:0]   = pix;
               2'd1:    stage_d[15:8]  = pix;
               default: stage_d[23:16] = pix;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_q    <= 2'd0;
         stage_q   <= '0;
         wr_addr_q <= '0;
      end else begin
         lane_q    <= lane_d;
         stage_q   <= stage_d;
         wr_addr_q <= wr_addr_d;
      end
   end

   // ---------------- FIFO ----------------
   logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
   logic [31:0]           data_mem [FIFO_DEPTH];
   logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
   logic [PW:0]           count_q, count_d;
   logic                  pop, push_ok, drop;
   logic                  frame_done_q, overflow_q;

   assign mem_wvalid = (count_q != '0);
   assign pop        = mem_wvalid & mem_wready;
   // A full FIFO can still take a word when the head leaves on the same edge.
   assign push_ok    = push & ((count_q != DEPTH_C) | pop);
   assign drop       = push & ~push_ok;
   assign mem_addr   = mem_wvalid ? addr_mem[rd_ptr_q] : '0;
   assign mem_data   = mem_wvalid ? data_mem[rd_ptr_q] : '0;

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage needs no reset: entries are only visible while count_q covers them.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         addr_mem[wr_ptr_q] <= cur_addr;
         data_mem[wr_ptr_q] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         count_q      <= count_d;
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         frame_done_q <= pop & (mem_addr == LAST_ADDR);
         if (drop)
            overflow_q <= 1'b1;
         else if (ovf_clear)
            overflow_q <= 1'b0;
      end
   end

   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;

endmodule
